// File: rtl/fdiv_seq_if.sv
// Handshake bundle for the sequential divider: operand side (x1/x2) and result side (y/ovf).
interface fdiv_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/fdiv_seq.sv
// Iterative binary32 divider y = x1 / x2, radix-2 restoring, one quotient bit per cycle.
// Number model matches fmul: no denormals/NaN/inf, exponent 0 is zero, truncated mantissa.
//
// state | meaning
// IDLE  | ready for operands
// CALC  | 25 restoring-division steps, MSB first
// NORM  | normalise quotient, apply special cases, register y/ovf
// DONE  | result held until out_ready
module fdiv_seq #(
  parameter bit DIV0_MAX_MAG = 1'b1
) (
  input logic     clk,
  input logic     rst,
  fdiv_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t        state_q, state_d;
  logic          sign_q;
  logic [7:0]    e1_q, e2_q;
  logic [25:0]   rem_q, div_q;
  logic [24:0]   quo_q;
  logic [4:0]    cnt_q;
  logic [31:0]   y_q;
  logic          ovf_q;
  logic          out_valid_q;

  logic          rem_ge;
  logic [25:0]   rem_sel;
  logic signed [9:0] exp_d;
  logic [22:0]   man_d;
  logic [31:0]   y_d;
  logic          ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = CALC;
      CALC: if (cnt_q == 5'd0) state_d = NORM;
      NORM: state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Remainder stays below div after selection, so the left shift never loses bit 25.
  assign rem_ge  = (rem_q >= div_q);
  assign rem_sel = rem_ge ? (rem_q - div_q) : rem_q;

  always_comb begin
    exp_d = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q})
            + (quo_q[24] ? 10'sd127 : 10'sd126);
    man_d = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
    y_d   = 32'd0;
    ovf_d = 1'b0;
    if (e2_q == 8'd0) begin
      y_d   = DIV0_MAX_MAG ? {sign_q, 31'h7F7FFFFF} : 32'd0;
      ovf_d = 1'b1;
    end else if (e1_q == 8'd0) begin
      y_d   = 32'd0;
      ovf_d = 1'b0;
    end else if (exp_d >= 10'sd255) begin
      y_d   = {sign_q, 31'h7F7FFFFF};
      ovf_d = 1'b1;
    end else if (exp_d <= 10'sd0) begin
      y_d   = 32'd0;
      ovf_d = 1'b1;
    end else begin
      y_d   = {sign_q, exp_d[7:0], man_d};
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q      <= 1'b0;
      e1_q        <= 8'd0;
      e2_q        <= 8'd0;
      rem_q       <= 26'd0;
      div_q       <= 26'd0;
      quo_q       <= 25'd0;
      cnt_q       <= 5'd0;
      y_q         <= 32'd0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q <= bus.x1[31] ^ bus.x2[31];
            e1_q   <= bus.x1[30:23];
            e2_q   <= bus.x2[30:23];
            rem_q  <= {2'b01, bus.x1[22:0]};
            div_q  <= {2'b01, bus.x2[22:0]};
            quo_q  <= 25'd0;
            cnt_q  <= 5'd24;
          end
        end
        CALC: begin
          // Quotient bits arrive MSB first, so shifting them in lands bit 24 on top after 25 steps.
          quo_q <= {quo_q[23:0], rem_ge};
          rem_q <= {rem_sel[24:0], 1'b0};
          if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end
        NORM: begin
          y_q         <= y_d;
          ovf_q       <= ovf_d;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Bench for fdiv_seq: two instances (divide-by-zero saturating and zeroing) driven in lockstep,
// checked every cycle against an arithmetic reference plus per-operation literal results.
module tb_fdiv_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fdiv_seq_if bus0();
  fdiv_seq_if bus1();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.x1        = bus0.x1;
  assign bus1.x2        = bus0.x2;
  assign bus1.out_ready = bus0.out_ready;

  fdiv_seq #(.DIV0_MAX_MAG(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  fdiv_seq #(.DIV0_MAX_MAG(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference result {ovf, y} from plain integer division.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input bit mag);
    int         e1, e2, ex;
    longint     n, d, q;
    logic       s;
    logic [22:0] m;
    e1 = int'(a[30:23]);
    e2 = int'(b[30:23]);
    s  = a[31] ^ b[31];
    n  = longint'({1'b1, a[22:0]});
    d  = longint'({1'b1, b[22:0]});
    q  = (n << 24) / d;
    if (e2 == 0) return {1'b1, (mag ? {s, 31'h7F7FFFFF} : 32'd0)};
    if (e1 == 0) return {1'b0, 32'd0};
    if (q >= 64'sd16777216) begin
      m  = q[23:1];
      ex = e1 - e2 + 127;
    end else begin
      m  = q[22:0];
      ex = e1 - e2 + 126;
    end
    if (ex >= 255) return {1'b1, s, 31'h7F7FFFFF};
    if (ex <= 0)   return {1'b1, 32'd0};
    return {1'b0, s, ex[7:0], m};
  endfunction

  // Transaction-level timing: idle, busy for a fixed 26 edges, then result held until taken.
  int          phase = 0;
  int          k = 0;
  logic [32:0] exp0 = '0;
  logic [32:0] exp1 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 0;
      k     <= 0;
    end else begin
      case (phase)
        0: if (bus0.in_valid) begin
             phase <= 1;
             k     <= 0;
             exp0  <= model(bus0.x1, bus0.x2, 1'b1);
             exp1  <= model(bus0.x1, bus0.x2, 1'b0);
           end
        1: begin
             k <= k + 1;
             if (k == 25) phase <= 2;
           end
        default: if (bus0.out_ready) phase <= 0;
      endcase
    end
  end

  logic [31:0] lit_y0 = '0, lit_y1 = '0;
  logic        lit_o0 = 1'b0, lit_o1 = 1'b0;
  bit          lit_en = 1'b0;
  bit          tmo = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  always begin
    @(negedge clk or posedge rst);
    if (rst) begin
      #1;
      chk1 ("rst_in_ready0",  bus0.in_ready,  1'b1);
      chk1 ("rst_out_valid0", bus0.out_valid, 1'b0);
      chk32("rst_y0",         bus0.y,         32'd0);
      chk1 ("rst_ovf0",       bus0.ovf,       1'b0);
      chk1 ("rst_in_ready1",  bus1.in_ready,  1'b1);
      chk1 ("rst_out_valid1", bus1.out_valid, 1'b0);
    end else begin
      chk1("timeout",    tmo,            1'b0);
      chk1("in_ready0",  bus0.in_ready,  phase == 0);
      chk1("out_valid0", bus0.out_valid, phase == 2);
      chk1("in_ready1",  bus1.in_ready,  phase == 0);
      chk1("out_valid1", bus1.out_valid, phase == 2);
      if (phase == 2) begin
        chk32("y0",   bus0.y,   exp0[31:0]);
        chk1 ("ovf0", bus0.ovf, exp0[32]);
        chk32("y1",   bus1.y,   exp1[31:0]);
        chk1 ("ovf1", bus1.ovf, exp1[32]);
        if (lit_en) begin
          chk32("lit_y0",   bus0.y,   lit_y0);
          chk1 ("lit_ovf0", bus0.ovf, lit_o0);
          chk32("lit_y1",   bus1.y,   lit_y1);
          chk1 ("lit_ovf1", bus1.ovf, lit_o1);
        end
      end
    end
  end

  task automatic set_lit(input logic [31:0] y0, input logic o0, input logic [31:0] y1, input logic o1);
    lit_y0 = y0; lit_o0 = o0; lit_y1 = y1; lit_o1 = o1; lit_en = 1'b1;
  endtask

  task automatic wait_result();
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (bus0.out_valid) break;
    end
    if (!bus0.out_valid) tmo = 1'b1;
  endtask

  task automatic consume(input int hold);
    repeat (hold) @(posedge clk);
    #1 bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
  endtask

  // Full transaction; in_valid stays high with junk operands for a few busy cycles to show they are ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] y0, input logic o0,
                        input logic [31:0] y1, input logic o1);
    @(posedge clk); #1;
    set_lit(y0, o0, y1, o1);
    bus0.x1 = a; bus0.x2 = b; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.x1 = $urandom; bus0.x2 = $urandom;
    repeat (4) @(posedge clk);
    #1 bus0.in_valid = 1'b0;
    wait_result();
    consume(2);
  endtask

  initial begin
    bus0.in_valid = 1'b0; bus0.x1 = '0; bus0.x2 = '0; bus0.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 32'h40400000, 1'b0);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 32'h3EAAAAAA, 1'b0);
    run_op(32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 1'b0, 32'hBEAAAAAA, 1'b0);
    run_op(32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 1'b1, 32'h00000000, 1'b1);
    run_op(32'hC0000000, 32'h00000000, 32'hFF7FFFFF, 1'b1, 32'h00000000, 1'b1);
    run_op(32'h7F000000, 32'h3E800000, 32'h7F7FFFFF, 1'b1, 32'h7F7FFFFF, 1'b1);
    run_op(32'h7F000000, 32'h3F000000, 32'h7F7FFFFF, 1'b1, 32'h7F7FFFFF, 1'b1);
    run_op(32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 32'h7F000000, 1'b0);
    run_op(32'h00800000, 32'h40800000, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
    run_op(32'h3F800000, 32'h7EC00000, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
    run_op(32'h3F800000, 32'h7E400000, 32'h00AAAAAA, 1'b0, 32'h00AAAAAA, 1'b0);
    run_op(32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0);

    // Long back-pressure, then a back-to-back operand pair offered together with the release.
    @(posedge clk); #1;
    set_lit(32'h40600000, 1'b0, 32'h40600000, 1'b0);
    bus0.x1 = 32'h40E00000; bus0.x2 = 32'h40000000; bus0.in_valid = 1'b1;
    @(posedge clk); #1 bus0.in_valid = 1'b0;
    wait_result();
    repeat (10) @(posedge clk);
    #1;
    bus0.out_ready = 1'b1; bus0.in_valid = 1'b1;
    bus0.x1 = 32'h41200000; bus0.x2 = 32'h40A00000;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    set_lit(32'h40000000, 1'b0, 32'h40000000, 1'b0);
    @(posedge clk); #1 bus0.in_valid = 1'b0;
    wait_result();
    consume(1);

    // Reset in the middle of CALC abandons the division.
    @(posedge clk); #1;
    set_lit(32'h3EAAAAAA, 1'b0, 32'h3EAAAAAA, 1'b0);
    bus0.x1 = 32'h3F800000; bus0.x2 = 32'h40400000; bus0.in_valid = 1'b1;
    @(posedge clk); #1 bus0.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #3 rst = 1'b1;
    #3 rst = 1'b0;
    run_op(32'hC0400000, 32'h3F000000, 32'hC0C00000, 1'b0, 32'hC0C00000, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
